// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: 4-stage execution counter, program counter,
// instruction register and two-flop handshake synchroniser feeding the decoder.
module fetch_sequencer #(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned PROG_LEN = 256
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Run,
    input  logic [11:0]         ProgData,
    input  logic                HandshakeIn,
    input  logic                PCHold,
    output logic [PC_WIDTH-1:0] ProgAddr,
    output logic [11:0]         Instruction,
    output logic [1:0]          Stage,
    output logic                Handshake,
    output logic                InstrDone
);

    typedef enum logic [1:0] {
        STAGE_FETCH  = 2'd0,
        STAGE_READ   = 2'd1,
        STAGE_EXEC   = 2'd2,
        STAGE_COMMIT = 2'd3
    } stage_t;

    localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(PROG_LEN - 1);

    stage_t              stage_q, stage_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [11:0]         ir_q, ir_d;
    logic                sync1_q, sync2_q;
    logic                instr_done;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stage_q <= STAGE_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            stage_q <= stage_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Memory read data is valid during STAGE_READ, so the IR captures it on
    // the edge leaving that stage; PC only moves on the edge leaving COMMIT.
    always_comb begin
        stage_d    = stage_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        instr_done = 1'b0;
        if (Run) begin
            case (stage_q)
                STAGE_FETCH: stage_d = STAGE_READ;
                STAGE_READ: begin
                    stage_d = STAGE_EXEC;
                    ir_d    = ProgData;
                end
                STAGE_EXEC: stage_d = STAGE_COMMIT;
                STAGE_COMMIT: begin
                    stage_d = STAGE_FETCH;
                    if (!PCHold) begin
                        instr_done = 1'b1;
                        pc_d       = (pc_q == PC_LAST) ? '0 : pc_q + PC_WIDTH'(1);
                    end
                end
                default: stage_d = STAGE_FETCH;
            endcase
        end
    end

    // Synchroniser runs regardless of Run so waits on the handshake stay live.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= HandshakeIn;
            sync2_q <= sync1_q;
        end
    end

    assign ProgAddr    = pc_q;
    assign Instruction = ir_q;
    assign Stage       = stage_q;
    assign Handshake   = sync2_q;
    assign InstrDone   = instr_done;

endmodule
